// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter.
//   arb_owner_e : current bus owner (normal arbitration or locked external burst)
//   mem_req_t   : one master's access payload (we/sel/addr/wdata)
//   cnt_w       : width of a counter that must hold 0..limit
package ram_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_SEL_W  = 4;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_EXT  = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_SEL_W-1:0]  sel;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic int unsigned cnt_w(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM masters (core ex-stage, external loader),
// the arbiter and the data RAM.
//   slave  : arbiter view (takes requests, drives grants and the RAM port)
//   master : environment view (drives requests and RAM read data)
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic                  core_req;
    logic                  core_we;
    logic [MEM_SEL_W-1:0]  core_sel;
    logic [MEM_ADDR_W-1:0] core_addr;
    logic [MEM_DATA_W-1:0] core_wdata;
    logic                  core_gnt;
    logic [MEM_DATA_W-1:0] core_rdata;
    logic                  core_hold;

    logic                  ext_req;
    logic                  ext_we;
    logic                  ext_lock;
    logic [MEM_SEL_W-1:0]  ext_sel;
    logic [MEM_ADDR_W-1:0] ext_addr;
    logic [MEM_DATA_W-1:0] ext_wdata;
    logic                  ext_gnt;
    logic [MEM_DATA_W-1:0] ext_rdata;

    logic                  ram_we;
    logic [MEM_SEL_W-1:0]  ram_sel;
    logic [MEM_ADDR_W-1:0] ram_wraddr;
    logic [MEM_DATA_W-1:0] ram_wdata;
    logic [MEM_DATA_W-1:0] ram_rdata;

    modport slave (
        input  core_req, core_we, core_sel, core_addr, core_wdata,
        output core_gnt, core_rdata, core_hold,
        input  ext_req, ext_we, ext_lock, ext_sel, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata,
        output ram_we, ram_sel, ram_wraddr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output core_req, core_we, core_sel, core_addr, core_wdata,
        input  core_gnt, core_rdata, core_hold,
        output ext_req, ext_we, ext_lock, ext_sel, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata,
        input  ram_we, ram_sel, ram_wraddr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single data RAM.
// Core has priority; a waiting external master wins once it has been denied
// STARVE_LIMIT consecutive cycles, and a locked external burst is capped at
// BURST_MAX grants while the core waits. Grants and the RAM drive are
// combinational (zero-cycle access); owner and counters are registered.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : ram_arbiter_if.slave (core_*, ext_*, ram_* signals)
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_MAX    = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam int unsigned WAIT_W  = cnt_w(STARVE_LIMIT);
    localparam int unsigned BURST_W = cnt_w(BURST_MAX);
    localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(STARVE_LIMIT);
    localparam logic [BURST_W-1:0] BURST_SAT = BURST_W'(BURST_MAX);

    arb_owner_e         owner_q, owner_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic     core_gnt_c;
    logic     ext_gnt_c;
    mem_req_t core_r;
    mem_req_t ext_r;
    mem_req_t ram_r;

    // Grant decision; reset masks every grant.
    always_comb begin
        core_gnt_c = 1'b0;
        ext_gnt_c  = 1'b0;
        if (!rst) begin
            if (owner_q == ARB_EXT) begin
                ext_gnt_c = bus.ext_req & ~(bus.core_req & (burst_cnt_q == BURST_SAT));
            end else begin
                ext_gnt_c = bus.ext_req & (~bus.core_req | (wait_cnt_q == WAIT_SAT));
            end
            core_gnt_c = bus.core_req & ~ext_gnt_c;
        end
    end

    // RAM port mux; an idle port drives all zeros.
    always_comb begin
        core_r = '{we: bus.core_we, sel: bus.core_sel, addr: bus.core_addr, wdata: bus.core_wdata};
        ext_r  = '{we: bus.ext_we,  sel: bus.ext_sel,  addr: bus.ext_addr,  wdata: bus.ext_wdata};
        ram_r  = '0;
        if (ext_gnt_c) begin
            ram_r = ext_r;
        end else if (core_gnt_c) begin
            ram_r = core_r;
        end
    end

    assign bus.ram_we     = ram_r.we;
    assign bus.ram_sel    = ram_r.sel;
    assign bus.ram_wraddr = ram_r.addr;
    assign bus.ram_wdata  = ram_r.wdata;

    assign bus.core_gnt   = core_gnt_c;
    assign bus.ext_gnt    = ext_gnt_c;
    assign bus.core_hold  = bus.core_req & ~core_gnt_c & ~rst;
    assign bus.core_rdata = bus.ram_rdata;
    assign bus.ext_rdata  = bus.ram_rdata;

    // Owner FSM and starvation/burst counters, next-state.
    always_comb begin
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;

        if (ext_gnt_c || !bus.ext_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        if (owner_q == ARB_CORE) begin
            burst_cnt_d = '0;
            if (ext_gnt_c && bus.ext_lock) begin
                owner_d     = ARB_EXT;
                burst_cnt_d = BURST_W'(1);
            end
        end else begin
            // A denied or unlocked cycle ends the burst; the forced-release
            // cycle lands here because ext_gnt is low in it.
            if (!ext_gnt_c || !bus.ext_lock) begin
                owner_d     = ARB_CORE;
                burst_cnt_d = '0;
            end else if (burst_cnt_q != BURST_SAT) begin
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= ARB_CORE;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter (STARVE_LIMIT=4, BURST_MAX=8).
// The driver applies one directed vector per cycle and queues its
// hand-computed expectation; the monitor pops and compares on the falling edge.
module tb_ram_arbiter;

    logic clk;
    logic rst;

    ram_arbiter_if bus();

    ram_arbiter #(
        .STARVE_LIMIT(4),
        .BURST_MAX   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-writable RAM model with combinational read.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_sel[b]) mem[bus.ram_wraddr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
    end
    assign bus.ram_rdata = mem[bus.ram_wraddr[7:2]];

    typedef struct packed {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [3:0]  csel;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic        ereq;
        logic        ewe;
        logic        elock;
        logic [3:0]  esel;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
    } stim_t;

    typedef struct {
        string       tag;
        logic        cg;
        logic        eg;
        logic        hold;
        logic        we;
        logic [31:0] addr;
        logic        chk;
        logic [31:0] rd;
    } exp_t;

    stim_t nxt;
    exp_t  sb [$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [31:0] A_CORE = 32'h0000_0010;
    localparam logic [31:0] A_EXT  = 32'h0000_0020;
    localparam logic [31:0] A_BS   = 32'h1122_3344;
    localparam logic [31:0] D_BEEF = 32'hDEAD_BEEF;

    task automatic check(input string tag, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s at %0t: got %h, expected %h", tag, field, $time, act, exp);
        end
    endtask

    // Apply the staged vector after the edge and queue its expectation.
    task automatic cyc(input string tag, input logic cg, input logic eg, input logic hold,
                       input logic we, input logic [31:0] addr, input logic chk,
                       input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = nxt.rst;
        bus.core_req   = nxt.creq;
        bus.core_we    = nxt.cwe;
        bus.core_sel   = nxt.csel;
        bus.core_addr  = nxt.caddr;
        bus.core_wdata = nxt.cwdata;
        bus.ext_req    = nxt.ereq;
        bus.ext_we     = nxt.ewe;
        bus.ext_lock   = nxt.elock;
        bus.ext_sel    = nxt.esel;
        bus.ext_addr   = nxt.eaddr;
        bus.ext_wdata  = nxt.ewdata;
        e.tag  = tag;
        e.cg   = cg;
        e.eg   = eg;
        e.hold = hold;
        e.we   = we;
        e.addr = addr;
        e.chk  = chk;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, "core_gnt",   32'(bus.core_gnt),  32'(mon_e.cg));
            check(mon_e.tag, "ext_gnt",    32'(bus.ext_gnt),   32'(mon_e.eg));
            check(mon_e.tag, "core_hold",  32'(bus.core_hold), 32'(mon_e.hold));
            check(mon_e.tag, "ram_we",     32'(bus.ram_we),    32'(mon_e.we));
            check(mon_e.tag, "ram_wraddr", bus.ram_wraddr,     mon_e.addr);
            if (mon_e.chk) begin
                check(mon_e.tag, "rdata", mon_e.cg ? bus.core_rdata : bus.ext_rdata, mon_e.rd);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_sel   = '0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.ext_req    = 1'b0;
        bus.ext_we     = 1'b0;
        bus.ext_lock   = 1'b0;
        bus.ext_sel    = '0;
        bus.ext_addr   = '0;
        bus.ext_wdata  = '0;

        // Reset with both masters requesting: nothing granted, RAM port idle.
        nxt = '0;
        nxt.rst = 1'b1; nxt.creq = 1'b1; nxt.ereq = 1'b1;
        nxt.caddr = A_CORE; nxt.eaddr = A_EXT;
        repeat (2) cyc("reset", 0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Core only: write then read back.
        nxt = '0;
        nxt.creq = 1'b1; nxt.cwe = 1'b1; nxt.csel = 4'hF; nxt.caddr = A_CORE; nxt.cwdata = D_BEEF;
        cyc("core_wr", 1, 0, 0, 1, A_CORE, 0, 32'h0);
        nxt.cwe = 1'b0; nxt.cwdata = '0;
        cyc("core_rd", 1, 0, 0, 0, A_CORE, 1, D_BEEF);

        // Continuous contention: ext wins every 5th cycle.
        nxt.ereq = 1'b1; nxt.eaddr = A_EXT;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) cyc("starve_ext", 0, 1, 1, 0, A_EXT, 0, 32'h0);
            else            cyc("starve_core", 1, 0, 0, 0, A_CORE, 1, D_BEEF);
        end
        nxt = '0;
        cyc("idle0", 0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Locked burst capped at 8 grants once the core starts waiting.
        nxt.ereq = 1'b1; nxt.elock = 1'b1; nxt.eaddr = A_EXT;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                nxt.creq = 1'b1; nxt.caddr = A_CORE;
            end
            if (i < 8)       cyc("cap_ext", 0, 1, (i >= 2), 0, A_EXT, 0, 32'h0);
            else if (i == 8) cyc("cap_release", 1, 0, 0, 0, A_CORE, 1, D_BEEF);
            else if (i < 12) cyc("cap_core", 1, 0, 0, 0, A_CORE, 1, D_BEEF);
            else             cyc("cap_relock", 0, 1, 1, 0, A_EXT, 0, 32'h0);
        end
        nxt = '0;
        cyc("idle1", 0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Uncontended burst: 20 grants, counter saturates, next core request wins.
        nxt.ereq = 1'b1; nxt.elock = 1'b1; nxt.eaddr = A_EXT;
        repeat (20) cyc("burst_ext", 0, 1, 0, 0, A_EXT, 0, 32'h0);
        nxt.creq = 1'b1; nxt.caddr = A_CORE;
        cyc("burst_sat", 1, 0, 0, 0, A_CORE, 1, D_BEEF);
        nxt = '0;
        cyc("idle2", 0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Byte select: ext overwrites byte 0 only.
        nxt.creq = 1'b1; nxt.cwe = 1'b1; nxt.csel = 4'hF; nxt.caddr = A_BS; nxt.cwdata = 32'h1122_3344;
        cyc("bs_pre", 1, 0, 0, 1, A_BS, 0, 32'h0);
        nxt = '0;
        nxt.ereq = 1'b1; nxt.ewe = 1'b1; nxt.esel = 4'b0001; nxt.eaddr = A_BS; nxt.ewdata = 32'h0000_00AA;
        cyc("bs_ext_wr", 0, 1, 0, 1, A_BS, 0, 32'h0);
        nxt = '0;
        nxt.creq = 1'b1; nxt.caddr = A_BS;
        cyc("bs_rd", 1, 0, 0, 0, A_BS, 1, 32'h1122_33AA);

        // Reset in the third burst cycle, then core must win a tie.
        nxt = '0;
        nxt.ereq = 1'b1; nxt.elock = 1'b1; nxt.eaddr = A_EXT;
        repeat (2) cyc("rb_ext", 0, 1, 0, 0, A_EXT, 0, 32'h0);
        nxt.rst = 1'b1; nxt.creq = 1'b1; nxt.caddr = A_CORE;
        cyc("rb_reset", 0, 0, 0, 0, 32'h0, 0, 32'h0);
        nxt.rst = 1'b0;
        cyc("rb_after", 1, 0, 0, 0, A_CORE, 1, D_BEEF);
        nxt = '0;
        cyc("idle3", 0, 0, 0, 0, 32'h0, 0, 32'h0);

        repeat (2) @(negedge clk);
        check("end", "sb_left", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
